rom32: RTL and testbench

ROM32 -- requirements
Module: rom32

---
 rtl/rom32.sv | 64 ++++++
 tb/tb_rom32.sv | 119 +++++++++++
 2 files changed

// File: rtl/rom32.sv
// rom32: 32-bit read-only program memory.
// Registered read, one-cycle latency, out-of-range reads give zero.
module rom32 #(
   parameter int DEPTH = 64,
   parameter int AW    = 32
) (
   input  logic [AW-1:0] addr,
   input  logic          enable,
   input  logic          clk,
   output logic [31:0]   out,
   input  logic          rst
);

   localparam int LW = $clog2(DEPTH);

   logic [AW-1:0] w_addr_w;
   logic [LW-1:0] w_idx;
   logic          w_oor;
   logic [31:0]   w_rdata;
   logic [31:0]   r_out;

   function automatic logic [31:0] f_rom(input logic [LW-1:0] i);
      logic [31:0] v;
      v = 32'h0000_0000;
      case (int'(i))
         0: v = 32'h2008_0005;
         1: v = 32'h2009_000A;
         2: v = 32'h0109_5020;
         3: v = 32'hAC0A_0000;
         4: v = 32'h8C0B_0000;
         5: v = 32'h116A_0001;
         6: v = 32'h0000_0000;
         7: v = 32'h0800_0000;
         default: v = 32'h0000_0000;
      endcase
      return v;
   endfunction

   // Word address; byte-offset bits drop out here.
   assign w_addr_w = addr >> 2;
   assign w_idx    = w_addr_w[LW-1:0];
   // Any set bit above the index means past the end: no wrap.
   assign w_oor    = |(w_addr_w >> LW);

   // Table lookup, forced to zero out of range.
   always_comb begin
      w_rdata = 32'h0000_0000;
      if (!w_oor) begin
         w_rdata = f_rom(w_idx);
      end
   end

   // Output register: reset wins, otherwise load on enable, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= 32'h0000_0000;
      end else if (enable) begin
         r_out <= w_rdata;
      end
   end

   assign out = r_out;

endmodule

// File: tb/tb_rom32.sv
// tb_rom32: directed self-checking bench for rom32.
// Inputs change on falling edges; out sampled 1ns after rising edges.
module tb_rom32;

   logic [31:0] addr;
   logic        enable;
   logic        clk;
   logic [31:0] out;
   logic        rst;

   int n_checks;
   int n_errors;

   logic [31:0] exp_tab [0:7];

   rom32 #(.DEPTH(64), .AW(32)) dut (
      .addr   (addr),
      .enable (enable),
      .clk    (clk),
      .out    (out),
      .rst    (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic [31:0] a, input logic en, input logic r);
      @(negedge clk);
      addr   = a;
      enable = en;
      rst    = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: out=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] e;
      n_checks = 0;
      n_errors = 0;
      exp_tab[0] = 32'h2008_0005;
      exp_tab[1] = 32'h2009_000A;
      exp_tab[2] = 32'h0109_5020;
      exp_tab[3] = 32'hAC0A_0000;
      exp_tab[4] = 32'h8C0B_0000;
      exp_tab[5] = 32'h116A_0001;
      exp_tab[6] = 32'h0000_0000;
      exp_tab[7] = 32'h0800_0000;
      addr   = 32'h0;
      enable = 1'b0;
      rst    = 1'b0;

      step(32'h0, 1'b0, 1'b1);
      chk("reset", out, 32'h0000_0000);
      step(32'h0, 1'b1, 1'b0);
      chk("first_read", out, 32'h2008_0005);

      step(32'h4, 1'b1, 1'b0);
      chk("seq_4", out, 32'h2009_000A);
      step(32'h8, 1'b1, 1'b0);
      chk("seq_8", out, 32'h0109_5020);
      step(32'hC, 1'b1, 1'b0);
      chk("seq_c", out, 32'hAC0A_0000);

      step(32'h10, 1'b1, 1'b0);
      chk("rd_10", out, 32'h8C0B_0000);
      step(32'h14, 1'b0, 1'b0);
      chk("hold_14", out, 32'h8C0B_0000);
      step(32'h1C, 1'b0, 1'b0);
      chk("hold_1c", out, 32'h8C0B_0000);

      step(32'h15, 1'b1, 1'b0);
      chk("misalign_15", out, 32'h116A_0001);
      step(32'h100, 1'b1, 1'b0);
      chk("oor_100", out, 32'h0000_0000);
      step(32'h7, 1'b1, 1'b0);
      chk("misalign_7", out, 32'h2009_000A);
      step(32'h20, 1'b1, 1'b0);
      chk("word8_20", out, 32'h0000_0000);
      step(32'h1E, 1'b1, 1'b0);
      chk("misalign_1e", out, 32'h0800_0000);
      step(32'h104, 1'b1, 1'b0);
      chk("oor_104", out, 32'h0000_0000);
      step(32'h0, 1'b1, 1'b0);
      chk("rd_0", out, 32'h2008_0005);
      step(32'h8000_0004, 1'b1, 1'b0);
      chk("oor_msb", out, 32'h0000_0000);

      step(32'h8, 1'b1, 1'b0);
      chk("pre_rst", out, 32'h0109_5020);
      step(32'h4, 1'b1, 1'b1);
      chk("rst_prio", out, 32'h0000_0000);
      step(32'h4, 1'b1, 1'b0);
      chk("post_rst", out, 32'h2009_000A);
      step(32'h4, 1'b0, 1'b1);
      chk("rst_noen", out, 32'h0000_0000);
      step(32'h10, 1'b0, 1'b0);
      chk("hold_rst", out, 32'h0000_0000);

      for (int i = 0; i < 64; i++) begin
         step(32'(i * 4), 1'b1, 1'b0);
         e = (i < 8) ? exp_tab[i] : 32'h0000_0000;
         chk($sformatf("sweep_%0d", i), out, e);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
